// File: rtl/bridge_apb_sequencer_pkg.sv
// Shared types for the AXI-to-APB bridge control path.
package bridge_utils;

    // Command to the APB master and its status (shared with the master).
    typedef enum logic [1:0] {
        APB_DISABLE = 2'd0,
        APB_READ    = 2'd1,
        APB_WRITE   = 2'd2
    } apb_cmd_t;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_BUSY   = 2'd1,
        APB_SWITCH = 2'd2
    } apb_info_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } seq_state_t;

    // Which AXI side owns the APB master. Values double as request-vector indices.
    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_t;

    // APB command that starts a burst for the given side.
    function automatic apb_cmd_t grant_to_cmd(grant_t g);
        return (g == GNT_WR) ? APB_WRITE : APB_READ;
    endfunction

endpackage

// File: rtl/bridge_rr_arbiter.sv
// Two-way round-robin arbiter. req_i is indexed by grant_t; on a tie the side
// that did not win last time is granted. last_grant only moves on advance_i.
module bridge_rr_arbiter
    import bridge_utils::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       valid_o,
    output grant_t     gnt_o,
    output grant_t     last_grant_o
);

    grant_t last_grant_q, last_grant_d;

    assign valid_o      = |req_i;
    assign last_grant_o = last_grant_q;

    // Pick the winner among the current requests.
    always_comb begin
        gnt_o = GNT_RD;
        unique case (req_i)
            2'b01:   gnt_o = GNT_RD;
            2'b10:   gnt_o = GNT_WR;
            2'b11:   gnt_o = (last_grant_q == GNT_WR) ? GNT_RD : GNT_WR;
            default: gnt_o = GNT_RD;
        endcase
    end

    // Remember the winner only when the grant is actually taken.
    always_comb begin
        last_grant_d = last_grant_q;
        if (advance_i && valid_o) begin
            last_grant_d = gnt_o;
        end
    end

    // Reset to read so the first write wins a tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GNT_RD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/bridge_apb_sequencer.sv
// Sequences the shared APB master for the AXI write and read sides: arbitrates,
// issues a one-cycle command, waits for the master's switch status, reports
// done/error to the owning side and watches for stalled bursts.
module bridge_apb_sequencer
    import bridge_utils::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      wr_req_i,
    output logic      wr_done_o,
    output logic      wr_err_o,
    input  logic      rd_req_i,
    output logic      rd_done_o,
    output logic      rd_err_o,
    output apb_cmd_t  apb_cmd_o,
    input  apb_info_t apb_info_i,
    input  logic      apb_beat_i,
    input  logic      apb_slverr_i,
    output logic      busy_o,
    output logic      timeout_o
);

    localparam bit                   WdogEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] WdogLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    seq_state_t           state_q, state_d;
    grant_t               gnt_q, gnt_d;
    logic                 err_acc_q, err_acc_d;
    logic [CNT_WIDTH-1:0] wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;

    logic   arb_valid;
    logic   arb_advance;
    grant_t arb_gnt;
    grant_t arb_last;
    logic   beat_err;
    logic   wdog_hit;
    logic   burst_err;

    bridge_rr_arbiter u_arb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        ({wr_req_i, rd_req_i}),
        .advance_i    (arb_advance),
        .valid_o      (arb_valid),
        .gnt_o        (arb_gnt),
        .last_grant_o (arb_last)
    );

    assign beat_err  = apb_beat_i & apb_slverr_i;
    // A slave error on the final beat coincides with the switch cycle.
    assign burst_err = err_acc_q | beat_err;
    assign busy_o    = (state_q != IDLE);
    // The flag is visible in the very WAIT cycle that reaches the limit.
    assign timeout_o = timeout_q | wdog_hit;

    // Next-state, handshake outputs and watchdog.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        err_acc_d   = err_acc_q;
        wdog_d      = wdog_q;
        arb_advance = 1'b0;
        apb_cmd_o   = APB_DISABLE;
        wr_done_o   = 1'b0;
        wr_err_o    = 1'b0;
        rd_done_o   = 1'b0;
        rd_err_o    = 1'b0;
        wdog_hit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    arb_advance = 1'b1;
                    gnt_d       = arb_gnt;
                    err_acc_d   = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (apb_info_i == APB_IDLE) begin
                    apb_cmd_o = grant_to_cmd(gnt_q);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                err_acc_d = err_acc_q | beat_err;
                // Saturate so a very long stall cannot wrap the counter.
                if (wdog_q != '1) begin
                    wdog_d = wdog_q + CNT_WIDTH'(1);
                end
                wdog_hit = WdogEn && (wdog_q == WdogLast);
                if (apb_info_i == APB_SWITCH) begin
                    wr_done_o = (gnt_q == GNT_WR);
                    rd_done_o = (gnt_q == GNT_RD);
                    wr_err_o  = (gnt_q == GNT_WR) & burst_err;
                    rd_err_o  = (gnt_q == GNT_RD) & burst_err;
                    wdog_d    = '0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign timeout_d = timeout_q | wdog_hit;

    // State registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_RD;
            err_acc_q <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            err_acc_q <= err_acc_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    logic unused_last;
    assign unused_last = arb_last;

endmodule

// File: doc/bridge_apb_sequencer.md
Name: bridge_apb_sequencer

Overview:
- Controls the AXI-to-APB bridge datapath.
- Shares the single APB master between the AXI write side and the AXI read side, using two-way round-robin arbitration.
- Sequences the master through its command handshake: issue APB_READ/APB_WRITE, wait for APB_SWITCH, release with APB_DISABLE.
- Returns a per-burst done pulse and error status to the requesting AXI side, and runs a watchdog on stalled APB bursts.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT before the timeout flag sets. 0 disables the watchdog.
- CNT_WIDTH, 16: width of the watchdog counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  write side has a complete burst ready (address captured, all W beats in FIFO). Held until wr_done.
- wr_done  out  1  one-cycle pulse: APB write burst finished.
- wr_err  out  1  valid with wr_done. 1 = PSLVERR seen on any beat of the burst.
- rd_req  in  1  read side has a captured AR burst. Held until rd_done.
- rd_done  out  1  one-cycle pulse: APB read burst finished.
- rd_err  out  1  valid with rd_done. 1 = PSLVERR seen on any beat of the burst.
- apb_cmd  out  apb_cmd_t  command to the APB master: APB_DISABLE / APB_READ / APB_WRITE.
- apb_info  in  apb_info_t  master status: APB_IDLE / APB_BUSY / APB_SWITCH.
- apb_beat  in  1  APB beat completing this cycle (psel & penable & pready).
- apb_slverr  in  1  pslverr, qualified by apb_beat.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky watchdog flag. Cleared only by rst.

Behaviour:
- Reset (rst high at a clock edge):
  - state <= IDLE; apb_cmd = APB_DISABLE.
  - wr_done, rd_done, wr_err, rd_err, busy, timeout = 0.
  - last_grant <= GNT_RD, so the first write wins a tie. err_acc <= 0; wdog <= 0.
  - Reset mid-burst aborts silently: no done pulse is generated.
- apb_cmd = APB_DISABLE in every state and cycle except the single ISSUE cycle described below.
- IDLE:
  - Neither request high: stay in IDLE.
  - One request high: grant it.
  - Both high: grant the side that is not last_grant.
  - On a grant: latch gnt, update last_grant, clear err_acc, go to ISSUE.
- ISSUE:
  - If apb_info == APB_IDLE: drive apb_cmd = APB_WRITE (gnt = GNT_WR) or APB_READ (gnt = GNT_RD) for exactly this cycle, then go to WAIT.
  - Otherwise: hold APB_DISABLE and stay in ISSUE.
- WAIT:
  - Each cycle with apb_beat & apb_slverr: set err_acc.
  - wdog increments every cycle. When wdog == TIMEOUT_CYCLES - 1 and TIMEOUT_CYCLES != 0: set timeout. Keep waiting; the burst cannot be aborted.
  - When apb_info == APB_SWITCH:
    - Pulse the granted side's done, with err = err_acc | (apb_beat & apb_slverr) in the same cycle.
    - Clear wdog; go to RELEASE.
  - APB_DISABLE is already on apb_cmd, so the master leaves its done state on this edge.
- RELEASE:
  - One cycle that lets the master return to APB_IDLE.
  - Then go to IDLE. Requests sampled in this cycle are ignored.
- Latency:
  - Request rising in IDLE at cycle 0 with master idle: apb_cmd valid at cycle 1, WAIT from cycle 2.
  - APB_SWITCH at cycle N gives done at cycle N (combinational from state plus apb_info). Next grant possible at cycle N+2.
- Request rules:
  - A request dropped after grant has no effect; the burst completes and done still pulses.
  - A request must not be re-asserted for the same burst after done.
- Never both done signals in one cycle. Never two grants outstanding.

Decomposition:
- bridge_utils package:
  - apb_cmd_t and apb_info_t (shared with the APB master).
  - New types: seq_state_t {IDLE, ISSUE, WAIT, RELEASE} and grant_t {GNT_RD, GNT_WR}.
- Sub-module bridge_rr_arbiter:
  - Two-way round robin with inputs req[1:0] and advance, outputs gnt and last_grant register.
  - Reused for the planned multi-master extension.
- The watchdog counter stays inline.

Test Plan:
- wr_req=1 only, master idle, 4-beat burst, APB_SWITCH at cycle 8 -> APB_WRITE exactly at cycle 1; wr_done=1, wr_err=0 at cycle 8; busy=0 at cycle 10.
- wr_req and rd_req both high from reset, each held to done -> grant order WR, RD, WR, RD; cmd sequence APB_WRITE, APB_READ, ...; never two dones in one cycle.
- rd burst with apb_beat & apb_slverr on beat 2 of 4 -> rd_done with rd_err=1; the following write burst with no errors -> wr_err=0 (err_acc cleared).
- apb_info held APB_BUSY while in ISSUE for 3 cycles -> apb_cmd stays APB_DISABLE, command issued on the first APB_IDLE cycle.
- TIMEOUT_CYCLES=16, APB_SWITCH withheld 40 cycles -> timeout=1 at 16th WAIT cycle, stays 1; done still pulses at SWITCH; only rst clears timeout.
- rst asserted during WAIT -> next cycle state IDLE, apb_cmd=APB_DISABLE, no done pulse, busy=0, timeout=0.
